// File: rtl/acc_drain_if.sv
// acc_drain_if: accumulation-beat input and pixel-word output handshake bundle.
// Rev 1.0
`default_nettype none

interface acc_drain_if #(
   parameter int N_KERNEL = 3,
   parameter int B_PIXEL  = 16
);
   logic                            in_valid;
   logic [2*B_PIXEL*N_KERNEL-1:0]   acc;
   logic                            clk_en;
   logic                            out_valid;
   logic                            out_ready;
   logic [B_PIXEL-1:0]              out_data;
   logic                            out_last;

   modport slave (
      input  in_valid, acc, out_ready,
      output clk_en, out_valid, out_data, out_last
   );

   modport master (
      output in_valid, acc, out_ready,
      input  clk_en, out_valid, out_data, out_last
   );
endinterface

`default_nettype wire

// File: rtl/acc_drain.sv
// acc_drain: captures every L-th accumulator beat and serializes its lanes as rounded, saturated pixels.
// Rev 1.0
`default_nettype none

module acc_drain #(
   parameter int N_KERNEL = 3,
   parameter int B_PIXEL  = 16,
   parameter int B_CNT    = 16
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic [B_CNT-1:0]  cfg_len_i,
   input  wire logic [4:0]        cfg_shift_i,
   input  wire logic              sat_clr_i,
   output logic                   sat_flag_o,
   acc_drain_if.slave             bus
);

   localparam int W     = 2 * B_PIXEL;
   localparam int WV    = W + 1;
   localparam int IDX_W = (N_KERNEL > 1) ? $clog2(N_KERNEL) : 1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SEND = 1'b1;

   localparam logic signed [WV-1:0] P_MAX = {{(WV-B_PIXEL+1){1'b0}}, {(B_PIXEL-1){1'b1}}};
   localparam logic signed [WV-1:0] P_MIN = {{(WV-B_PIXEL+1){1'b1}}, {(B_PIXEL-1){1'b0}}};

   logic [B_CNT-1:0]              cnt_q, cnt_d;
   logic [IDX_W-1:0]              idx_q, idx_d;
   logic                          buf_full_q, buf_full_d;
   logic [N_KERNEL-1:0][W-1:0]    buf_q, buf_d;
   logic [0:0]                    state_q, state_d;
   logic                          sat_q, sat_d;

   logic [B_CNT-1:0]              len_m1;
   logic                          at_end;
   logic                          clk_en;
   logic                          accept;
   logic                          capture;
   logic                          hs;
   logic                          last_lane;
   logic [W-1:0]                  lane_sel;
   logic signed [WV-1:0]          v_ext, v_rnd, v_sum, v_shr;
   logic                          word_sat;
   logic [B_PIXEL-1:0]            word;

   assign len_m1 = (cfg_len_i == '0) ? '0 : cfg_len_i - B_CNT'(1);
   // >= rather than == keeps the counter from running away if cfg_len shrinks while idle.
   assign at_end    = (cnt_q >= len_m1);
   assign clk_en    = !(buf_full_q && at_end);
   assign accept    = bus.in_valid && clk_en;
   assign capture   = accept && at_end;
   assign hs        = (state_q == S_SEND) && bus.out_ready;
   assign last_lane = (idx_q == IDX_W'(N_KERNEL - 1));

   always_comb begin
      lane_sel = '0;
      for (int j = 0; j < N_KERNEL; j++) begin
         if (idx_q == IDX_W'(j)) begin
            lane_sel = buf_q[j];
         end
      end
   end

   always_comb begin
      v_ext    = {lane_sel[W-1], lane_sel};
      v_rnd    = (cfg_shift_i == 5'd0) ? '0 : (WV'(1) << (cfg_shift_i - 5'd1));
      v_sum    = v_ext + v_rnd;
      v_shr    = v_sum >>> cfg_shift_i;
      word_sat = (v_shr > P_MAX) || (v_shr < P_MIN);
      if (v_shr > P_MAX) begin
         word = P_MAX[B_PIXEL-1:0];
      end else if (v_shr < P_MIN) begin
         word = P_MIN[B_PIXEL-1:0];
      end else begin
         word = v_shr[B_PIXEL-1:0];
      end
   end

   always_comb begin
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      buf_full_d = buf_full_q;
      buf_d      = buf_q;
      state_d    = state_q;
      sat_d      = sat_q;

      if (accept) begin
         cnt_d = at_end ? '0 : cnt_q + B_CNT'(1);
      end

      // clk_en guarantees capture and last-lane handshake are never in the same cycle.
      if (capture) begin
         buf_d      = bus.acc;
         buf_full_d = 1'b1;
      end else if (hs && last_lane) begin
         buf_full_d = 1'b0;
      end

      if (hs) begin
         idx_d = last_lane ? '0 : idx_q + IDX_W'(1);
      end

      case (state_q)
         S_IDLE:  if (capture) state_d = S_SEND;
         S_SEND:  if (hs && last_lane) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (hs && word_sat) begin
         sat_d = 1'b1;
      end else if (sat_clr_i) begin
         sat_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q      <= '0;
         idx_q      <= '0;
         buf_full_q <= 1'b0;
         buf_q      <= '0;
         state_q    <= S_IDLE;
         sat_q      <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         buf_full_q <= buf_full_d;
         buf_q      <= buf_d;
         state_q    <= state_d;
         sat_q      <= sat_d;
      end
   end

   assign bus.clk_en    = clk_en;
   assign bus.out_valid = (state_q == S_SEND);
   assign bus.out_data  = (state_q == S_SEND) ? word : '0;
   assign bus.out_last  = (state_q == S_SEND) && last_lane;
   assign sat_flag_o    = sat_q;

endmodule

`default_nettype wire

// File: tb/tb_acc_drain.sv
// tb_acc_drain: directed vector table plus hand-written handshake, reset and sticky-flag sequences.
// Rev 1.0
`default_nettype none

module tb_acc_drain;

   localparam int NK = 3;
   localparam int BP = 16;
   localparam int BC = 16;

   typedef struct {
      logic [BC-1:0]      len;
      logic [4:0]         shift;
      logic [2:0][31:0]   lane;
      logic [2:0][15:0]   exp;
      logic               sat;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [BC-1:0] cfg_len;
   logic [4:0]    cfg_shift;
   logic          sat_clr;
   logic          sat_flag;

   int checks = 0;
   int errors = 0;

   vec_t v [7];

   always #5 clk = ~clk;

   acc_drain_if #(.N_KERNEL(NK), .B_PIXEL(BP)) bus ();

   acc_drain #(.N_KERNEL(NK), .B_PIXEL(BP), .B_CNT(BC)) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_len_i   (cfg_len),
      .cfg_shift_i (cfg_shift),
      .sat_clr_i   (sat_clr),
      .sat_flag_o  (sat_flag),
      .bus         (bus.slave)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [2:0][31:0] l);
      int t;
      bus.in_valid = 1'b1;
      bus.acc      = l;
      t = 0;
      while (!bus.clk_en && t < 200) begin
         step();
         t++;
      end
      if (t >= 200) begin
         checks++;
         errors++;
         $display("FAIL clk_en_timeout actual=0 expected=1");
      end
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic recv(input string nm, input logic [2:0][15:0] e);
      int t;
      for (int k = 0; k < NK; k++) begin
         t = 0;
         while (!bus.out_valid && t < 50) begin
            step();
            t++;
         end
         chk($sformatf("%s_valid%0d", nm, k), {31'b0, bus.out_valid}, 32'd1);
         chk($sformatf("%s_data%0d", nm, k), {16'b0, bus.out_data}, {16'b0, e[k]});
         chk($sformatf("%s_last%0d", nm, k), {31'b0, bus.out_last}, (k == NK - 1) ? 32'd1 : 32'd0);
         step();
      end
   endtask

   task automatic run_frame(input string nm, input vec_t f);
      int n;
      cfg_len       = f.len;
      cfg_shift     = f.shift;
      bus.out_ready = 1'b1;
      n = (f.len == '0) ? 1 : int'(f.len);
      for (int b = 0; b < n - 1; b++) begin
         send_beat({32'd3, 32'd2, 32'd1});
      end
      send_beat(f.lane);
      recv(nm, f.exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      v[0] = '{len: 16'd2, shift: 5'd0, lane: {32'd30, 32'd20, 32'd10},
               exp: {16'd30, 16'd20, 16'd10}, sat: 1'b0};
      v[1] = '{len: 16'd1, shift: 5'd4, lane: {32'd7, 32'hFFFF_FFE8, 32'd24},
               exp: {16'd0, 16'hFFFF, 16'd2}, sat: 1'b0};
      v[2] = '{len: 16'd1, shift: 5'd0, lane: {32'd5, 32'hFFFF_0000, 32'h0001_0000},
               exp: {16'd5, 16'h8000, 16'h7FFF}, sat: 1'b1};
      v[3] = '{len: 16'd0, shift: 5'd0, lane: {32'd6, 32'd5, 32'd4},
               exp: {16'd6, 16'd5, 16'd4}, sat: 1'b0};
      v[4] = '{len: 16'd0, shift: 5'd0, lane: {32'd9, 32'd8, 32'd7},
               exp: {16'd9, 16'd8, 16'd7}, sat: 1'b0};
      v[5] = '{len: 16'd3, shift: 5'd1, lane: {32'h7FFF_FFFF, 32'd3, 32'hFFFF_FFFD},
               exp: {16'h7FFF, 16'd2, 16'hFFFF}, sat: 1'b1};
      v[6] = '{len: 16'd1, shift: 5'd31, lane: {32'd0, 32'h7FFF_FFFF, 32'h8000_0000},
               exp: {16'd0, 16'd1, 16'hFFFF}, sat: 1'b0};

      rst           = 1'b1;
      cfg_len       = 16'd1;
      cfg_shift     = 5'd0;
      sat_clr       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.acc       = '0;
      bus.out_ready = 1'b0;
      step();
      step();
      chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_out_last",  {31'b0, bus.out_last},  32'd0);
      chk("rst_out_data",  {16'b0, bus.out_data},  32'd0);
      chk("rst_clk_en",    {31'b0, bus.clk_en},    32'd1);
      chk("rst_sat_flag",  {31'b0, sat_flag},      32'd0);
      rst = 1'b0;
      step();

      for (int i = 0; i < 7; i++) begin
         sat_clr = 1'b1;
         step();
         sat_clr = 1'b0;
         run_frame($sformatf("vec%0d", i), v[i]);
         chk($sformatf("vec%0d_sat", i), {31'b0, sat_flag}, {31'b0, v[i].sat});
      end

      // Backpressure with in_valid held high.
      sat_clr = 1'b1;
      step();
      sat_clr       = 1'b0;
      cfg_len       = 16'd1;
      cfg_shift     = 5'd0;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.acc       = {32'd13, 32'd12, 32'd11};
      step();
      chk("bp_clk_en0",  {31'b0, bus.clk_en},    32'd0);
      chk("bp_valid",    {31'b0, bus.out_valid}, 32'd1);
      chk("bp_data0",    {16'b0, bus.out_data},  32'd11);
      step();
      step();
      chk("bp_clk_en1",  {31'b0, bus.clk_en},    32'd0);
      chk("bp_stable",   {16'b0, bus.out_data},  32'd11);
      chk("bp_last0",    {31'b0, bus.out_last},  32'd0);
      bus.acc       = {32'd23, 32'd22, 32'd21};
      bus.out_ready = 1'b1;
      chk("bp_w0", {16'b0, bus.out_data}, 32'd11);
      step();
      chk("bp_w1", {16'b0, bus.out_data}, 32'd12);
      chk("bp_clk_en2", {31'b0, bus.clk_en}, 32'd0);
      step();
      chk("bp_w2",    {16'b0, bus.out_data}, 32'd13);
      chk("bp_last2", {31'b0, bus.out_last}, 32'd1);
      step();
      chk("bp_clk_en_back", {31'b0, bus.clk_en},    32'd1);
      chk("bp_idle",        {31'b0, bus.out_valid}, 32'd0);
      step();
      bus.in_valid = 1'b0;
      recv("bp_next", {16'd23, 16'd22, 16'd21});

      // Simultaneous saturation set and clear, then sticky hold and clear.
      bus.out_ready = 1'b0;
      send_beat({32'd0, 32'd0, 32'h0001_0000});
      chk("sc_word", {16'b0, bus.out_data}, 32'h7FFF);
      sat_clr       = 1'b1;
      bus.out_ready = 1'b1;
      step();
      sat_clr = 1'b0;
      chk("sc_set_wins", {31'b0, sat_flag}, 32'd1);
      step();
      step();
      chk("sc_frame_done", {31'b0, bus.out_valid}, 32'd0);
      step();
      step();
      chk("sc_sticky", {31'b0, sat_flag}, 32'd1);
      sat_clr = 1'b1;
      step();
      sat_clr = 1'b0;
      chk("sc_cleared", {31'b0, sat_flag}, 32'd0);

      // Asynchronous reset after the first word of a saturating frame.
      send_beat({32'd2, 32'd1, 32'h0001_0000});
      step();
      chk("ar_pre_sat", {31'b0, sat_flag}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_valid",  {31'b0, bus.out_valid}, 32'd0);
      chk("ar_clk_en", {31'b0, bus.clk_en},    32'd1);
      chk("ar_sat",    {31'b0, sat_flag},      32'd0);
      chk("ar_data",   {16'b0, bus.out_data},  32'd0);
      step();
      rst = 1'b0;
      step();
      // Abandon a partially counted frame, then confirm counting restarts at zero.
      cfg_len = 16'd2;
      send_beat({32'd99, 32'd99, 32'd99});
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      run_frame("ar_next", '{len: 16'd2, shift: 5'd0, lane: {32'd6, 32'd5, 32'd4},
                             exp: {16'd6, 16'd5, 16'd4}, sat: 1'b0});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
